// File: rtl/toplevel_c5g_led_switch_7segx2_gpio_uart.sv
// ----------------------------------------------------------------------------
// toplevel_c5g_led_switch_7segx2_gpio_uart
// Delta-sigma DAC demo top level for the C5G board, all on CLOCK_50_B5B.
//   KEY[0]/KEY[1]  : active-low frequency up/down buttons (2-FF sync + edge)
//   SW[1:0]        : amplitude attenuation (arithmetic right shift 0..3)
//   LEDR           : f_sel[9:0]
//   HEX0/HEX1      : active-low hex digits of f_sel[3:0] / f_sel[7:4]
//   LEDG[0]        : DSM bit, LEDG[7:1] = 0
//   GPIO[0]/GPIO[1]: DSM bit / inverted DSM bit, GPIO[35:2] = 0
//   UART_TX        : idle high
//   CPU_RESET_n    : active-low board reset, used as synchronous rst
// Pipeline: acc -> ROM address reg -> ROM data reg -> shift/convert reg ->
// DSM reg, i.e. 4 clocks from phase accumulator to GPIO[0].
// ----------------------------------------------------------------------------

// Sine table, 65536 x 16 bit, registered address and registered data.
// The table contents are a parabolic approximation of one two's-complement
// sine period, computed from the address so no init file is needed.
module rom_addr16bit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] addr_i,
    output logic [15:0] q_o
);
    logic [15:0] addr_q;
    logic [15:0] q_q;

    // Half-wave parabola x*(32767-x)/8192, negated in the second half.
    function automatic logic [15:0] sine_word(input logic [15:0] a);
        logic [14:0] x;
        logic [29:0] p;
        logic [15:0] y;
        x = a[14:0];
        p = {15'd0, x} * {15'd0, 15'h7FFF - x};
        y = {1'b0, p[27:13]};
        if (a[15]) begin
            sine_word = 16'd0 - y;
        end else begin
            sine_word = y;
        end
    endfunction

    // Address and output registers; table contents are not affected by rst.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= 16'd0;
            q_q    <= 16'd0;
        end else begin
            addr_q <= addr_i;
            q_q    <= sine_word(addr_q);
        end
    end

    assign q_o = q_q;
endmodule

module toplevel_c5g_led_switch_7segx2_gpio_uart (
    input  logic        CLOCK_125_p,
    input  logic        CLOCK_50_B5B,
    input  logic        CLOCK_50_B6A,
    input  logic        CLOCK_50_B7A,
    input  logic        CLOCK_50_B8A,
    input  logic        CPU_RESET_n,
    input  logic [3:0]  KEY,
    input  logic [9:0]  SW,
    input  logic        UART_RX,
    output logic [7:0]  LEDG,
    output logic [9:0]  LEDR,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic        UART_TX,
    output logic [35:0] GPIO
);
    logic        rst;
    logic [1:0]  key_s1_q, key_s2_q, key_prev_q;
    logic        up_pulse_s, dn_pulse_s;
    logic [15:0] f_sel_q, f_sel_d;
    logic [23:0] acc_q;
    logic [15:0] rom_data_s;
    logic signed [15:0] shifted_s;
    logic [15:0] u_q;
    logic [16:0] dacc_d;
    logic [15:0] dacc_q;
    logic [1:0]  gpio_q;
    logic [9:0]  ledr_q;
    logic [6:0]  hex0_q, hex1_q;
    logic        unused_s;

    assign rst = ~CPU_RESET_n;

    // Active-low 7-segment patterns {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1111000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0010000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b1000110;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000110;
            4'hF:    seg7 = 7'b0001110;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Key synchronizers; reset to the released level so no false press.
    always_ff @(posedge CLOCK_50_B5B) begin
        if (rst) begin
            key_s1_q   <= 2'b11;
            key_s2_q   <= 2'b11;
            key_prev_q <= 2'b11;
        end else begin
            key_s1_q   <= KEY[1:0];
            key_s2_q   <= key_s1_q;
            key_prev_q <= key_s2_q;
        end
    end

    assign up_pulse_s = key_prev_q[0] & ~key_s2_q[0];
    assign dn_pulse_s = key_prev_q[1] & ~key_s2_q[1];

    // Saturating up/down frequency select; simultaneous pulses cancel.
    always_comb begin
        f_sel_d = f_sel_q;
        case ({up_pulse_s, dn_pulse_s})
            2'b10: begin
                if (f_sel_q != 16'hFFFF) begin
                    f_sel_d = f_sel_q + 16'd1;
                end else begin
                    f_sel_d = f_sel_q;
                end
            end
            2'b01: begin
                if (f_sel_q != 16'h0000) begin
                    f_sel_d = f_sel_q - 16'd1;
                end else begin
                    f_sel_d = f_sel_q;
                end
            end
            default: f_sel_d = f_sel_q;
        endcase
    end

    // Frequency register and 24-bit phase accumulator.
    always_ff @(posedge CLOCK_50_B5B) begin
        if (rst) begin
            f_sel_q <= 16'd0;
            acc_q   <= 24'd0;
        end else begin
            f_sel_q <= f_sel_d;
            acc_q   <= acc_q + {8'd0, f_sel_q};
        end
    end

    rom_addr16bit u0_rom_addr16bit (
        .clk_i  (CLOCK_50_B5B),
        .rst_i  (rst),
        .addr_i (acc_q[23:8]),
        .q_o    (rom_data_s)
    );

    assign shifted_s = $signed(rom_data_s) >>> SW[1:0];
    // Carry out of the lower 16 bits is the DSM bit; only the low half is kept.
    assign dacc_d    = {1'b0, dacc_q} + {1'b0, u_q};

    // Attenuate/offset stage and first-order delta-sigma modulator.
    always_ff @(posedge CLOCK_50_B5B) begin
        if (rst) begin
            u_q    <= 16'h8000;
            dacc_q <= 16'd0;
            gpio_q <= 2'b10;
        end else begin
            u_q    <= $unsigned(shifted_s) ^ 16'h8000;
            dacc_q <= dacc_d[15:0];
            gpio_q <= {~dacc_d[16], dacc_d[16]};
        end
    end

    // Status display registers, one clock behind f_sel.
    always_ff @(posedge CLOCK_50_B5B) begin
        if (rst) begin
            ledr_q <= 10'd0;
            hex0_q <= 7'b1000000;
            hex1_q <= 7'b1000000;
        end else begin
            ledr_q <= f_sel_q[9:0];
            hex0_q <= seg7(f_sel_q[3:0]);
            hex1_q <= seg7(f_sel_q[7:4]);
        end
    end

    assign LEDR    = ledr_q;
    assign HEX0    = hex0_q;
    assign HEX1    = hex1_q;
    assign LEDG    = {7'd0, gpio_q[0]};
    assign GPIO    = {34'd0, gpio_q};
    assign UART_TX = 1'b1;

    assign unused_s = ^{CLOCK_125_p, CLOCK_50_B6A, CLOCK_50_B7A, CLOCK_50_B8A,
                        UART_RX, KEY[3:2], SW[9:2]};
endmodule

// File: tb/tb_toplevel_c5g_led_switch_7segx2_gpio_uart.sv
module tb_toplevel_c5g_led_switch_7segx2_gpio_uart;
    logic        clk = 1'b0;
    logic        CPU_RESET_n;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [7:0]  LEDG;
    logic [9:0]  LEDR;
    logic [6:0]  HEX0, HEX1;
    logic        UART_TX;
    logic [35:0] GPIO;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model state
    int        m_fsel, m_acc, m_dacc, m_u;
    int        acc_hist [3];   // [0] = acc after previous edge, [2] = three edges back
    bit        kh0 [3];        // KEY[0] samples, [0] newest
    bit        kh1 [3];
    bit        e_dsm;
    logic [15:0] e_ledr;

    always #10 clk = ~clk;

    toplevel_c5g_led_switch_7segx2_gpio_uart dut (
        .CLOCK_125_p  (1'b0),
        .CLOCK_50_B5B (clk),
        .CLOCK_50_B6A (1'b0),
        .CLOCK_50_B7A (1'b0),
        .CLOCK_50_B8A (1'b0),
        .CPU_RESET_n  (CPU_RESET_n),
        .KEY          (KEY),
        .SW           (SW),
        .UART_RX      (1'b1),
        .LEDG         (LEDG),
        .LEDR         (LEDR),
        .HEX0         (HEX0),
        .HEX1         (HEX1),
        .UART_TX      (UART_TX),
        .GPIO         (GPIO)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // One period of the sine table: parabola x*(32767-x)/8192, negative half mirrored.
    function automatic int rom_ref(input int a);
        int x, y;
        x = a % 32768;
        y = (x * (32767 - x)) / 8192;
        return (a >= 32768) ? -y : y;
    endfunction

    // Attenuated sample as offset binary.
    function automatic int conv(input int s, input int sh);
        int v;
        v = s >>> sh;
        return (v + 32768) & 65535;
    endfunction

    task automatic model_step();
        int sum, old_f;
        bit up, dn;
        if (!CPU_RESET_n) begin
            m_fsel = 0; m_acc = 0; m_dacc = 0; m_u = 32768;
            for (int i = 0; i < 3; i++) begin
                acc_hist[i] = 0; kh0[i] = 1'b1; kh1[i] = 1'b1;
            end
            e_dsm = 1'b0; e_ledr = 16'd0;
        end else begin
            sum    = m_dacc + m_u;
            e_dsm  = (sum >= 65536);
            m_dacc = sum % 65536;
            m_u    = conv(rom_ref(acc_hist[2] / 256), int'(SW[1:0]));
            e_ledr = m_fsel[15:0];
            up = kh0[2] && !kh0[1];
            dn = kh1[2] && !kh1[1];
            old_f = m_fsel;
            if (up && !dn && m_fsel < 65535) m_fsel = m_fsel + 1;
            else if (dn && !up && m_fsel > 0) m_fsel = m_fsel - 1;
            m_acc = (m_acc + old_f) % (1 << 24);
            acc_hist[2] = acc_hist[1]; acc_hist[1] = acc_hist[0]; acc_hist[0] = m_acc;
            kh0[2] = kh0[1]; kh0[1] = kh0[0]; kh0[0] = KEY[0];
            kh1[2] = kh1[1]; kh1[1] = kh1[0]; kh1[0] = KEY[1];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("gpio", {28'd0, GPIO}, {28'd0, 34'd0, ~e_dsm, e_dsm});
        check_eq("ledg", {56'd0, LEDG}, {56'd0, 7'd0, e_dsm});
        check_eq("ledr", {54'd0, LEDR}, {54'd0, e_ledr[9:0]});
        check_eq("hex0", {57'd0, HEX0}, {57'd0, seg_tab[e_ledr[3:0]]});
        check_eq("hex1", {57'd0, HEX1}, {57'd0, seg_tab[e_ledr[7:4]]});
        check_eq("uart_tx", {63'd0, UART_TX}, 64'd1);
    endtask

    task automatic press(input logic [1:0] mask, input int low_cyc, input int high_cyc);
        KEY = {2'b11, ~mask};
        repeat (low_cyc) tick();
        KEY = 4'hF;
        repeat (high_cyc) tick();
    endtask

    initial begin
        CPU_RESET_n = 1'b0; KEY = 4'hF; SW = 10'd0;
        // Reset low for 99 ns
        repeat (5) tick();
        #8;
        CPU_RESET_n = 1'b1;
        check_eq("rst_ledr", {54'd0, LEDR}, 64'd0);
        check_eq("rst_hex0", {57'd0, HEX0}, 64'h40);
        check_eq("rst_hex1", {57'd0, HEX1}, 64'h40);
        check_eq("rst_gpio", {28'd0, GPIO}, 64'h2);
        // f_sel=0, ROM word 0 -> 50 % pattern
        repeat (24) tick();

        // 300 up presses
        for (int i = 0; i < 300; i++) press(2'b01, 3, 1);
        repeat (5) tick();
        check_eq("ledr_300", {54'd0, LEDR}, 64'h12C);
        check_eq("hex0_300", {57'd0, HEX0}, {57'd0, 7'b1000110});
        check_eq("hex1_300", {57'd0, HEX1}, {57'd0, 7'b0100100});

        // sine running, full amplitude then attenuated
        repeat (400) tick();
        SW = 10'd3;
        repeat (400) tick();
        SW = 10'd1;
        repeat (100) tick();
        SW = 10'd0;

        // simultaneous presses cancel
        for (int i = 0; i < 4; i++) press(2'b11, 2, 1);
        repeat (5) tick();
        check_eq("ledr_both", {54'd0, LEDR}, 64'h12C);

        // 555 down presses saturate at 0, single-cycle release between presses
        for (int i = 0; i < 555; i++) press(2'b10, 2, 1);
        repeat (5) tick();
        check_eq("ledr_sat0", {54'd0, LEDR}, 64'h0);
        repeat (100) tick();

        // randomized key / switch / reset activity
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 55)      KEY = 4'b1110;
            else if (r < 65) KEY = 4'b1101;
            else if (r < 70) KEY = 4'b1100;
            else             KEY = 4'b1111;
            if ($urandom_range(0, 49) == 0) SW = 10'($urandom);
            if ($urandom_range(0, 299) == 0) CPU_RESET_n = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            CPU_RESET_n = 1'b1;
        end
        KEY = 4'hF;
        repeat (20) tick();

        // reset mid-operation: f_sel and phase restart
        CPU_RESET_n = 1'b0;
        tick();
        CPU_RESET_n = 1'b1;
        check_eq("midrst_ledr", {54'd0, LEDR}, 64'h0);
        check_eq("midrst_gpio", {28'd0, GPIO}, 64'h2);
        repeat (300) tick();
        check_eq("post_rst_ledr", {54'd0, LEDR}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
